// File: rtl/flag_reg_stack_if.sv
// rtl/flag_reg_stack_if.sv - flag register control/status bundle
interface flag_reg_stack_if #(
  parameter int Width = 3,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             write_enable;
  logic [Width-1:0] write_mask;
  logic [Width-1:0] write_data;
  logic             set_carry;
  logic             clear_carry;
  logic             push;
  logic             pop;
  logic [Width-1:0] read_data;
  logic [DW-1:0]    stk_depth;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_err;

  modport master (
    output write_enable, write_mask, write_data, set_carry, clear_carry, push, pop,
    input  read_data, stk_depth, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  write_enable, write_mask, write_data, set_carry, clear_carry, push, pop,
    output read_data, stk_depth, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/flag_reg_stack.sv
// rtl/flag_reg_stack.sv - condition-code register with masked writes and save/restore stack
module flag_reg_stack #(
  parameter int Width     = 3,
  parameter int DEPTH     = 4,
  parameter int CARRY_BIT = 2
) (
  input logic                 clk,
  input logic                 reset,
  flag_reg_stack_if.slave     bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [Width-1:0] flags;
  logic [Width-1:0] nxt_flags;
  logic [Width-1:0] stack [2**AW];
  logic [DW-1:0]    depth;
  logic [DW-1:0]    depth_m1;
  logic             err;
  logic             full;
  logic             empty;
  logic             push_only;
  logic             pop_only;
  logic             do_push;
  logic             do_pop;
  logic             collide;

  assign full      = (depth == DW'(DEPTH));
  assign empty     = (depth == '0);
  assign push_only = bus.push & ~bus.pop;
  assign pop_only  = bus.pop & ~bus.push;
  assign collide   = bus.push & bus.pop;
  assign do_push   = push_only & ~full;
  assign do_pop    = pop_only & ~empty;
  assign depth_m1  = depth - DW'(1);

  // Steps 1-4; a valid pop replaces the whole result in the register update.
  always_comb begin
    nxt_flags = flags;
    if (bus.write_enable)
      nxt_flags = (flags & ~bus.write_mask) | (bus.write_data & bus.write_mask);
    if (bus.clear_carry)
      nxt_flags[CARRY_BIT] = 1'b0;
    if (bus.set_carry)
      nxt_flags[CARRY_BIT] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
      depth <= '0;
      err   <= 1'b0;
    end else begin
      flags <= do_pop ? stack[depth_m1[AW-1:0]] : nxt_flags;
      if (do_push)
        depth <= depth + DW'(1);
      else if (do_pop)
        depth <= depth_m1;
      if (collide || (push_only && full) || (pop_only && empty))
        err <= 1'b1;
    end
  end

  // Contents need no reset; only entries below depth are ever read.
  always_ff @(posedge clk) begin
    if (!reset && do_push)
      stack[depth[AW-1:0]] <= flags;
  end

  assign bus.read_data = flags;
  assign bus.stk_depth = depth;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.stk_err   = err;
endmodule

// File: tb/tb_flag_reg_stack.sv
// tb/tb_flag_reg_stack.sv - directed bench for flag_reg_stack
module tb_flag_reg_stack;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  flag_reg_stack_if #(.Width(3), .DEPTH(4)) intf ();

  flag_reg_stack #(.Width(3), .DEPTH(4), .CARRY_BIT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf.slave)
  );

  always #5 clk = ~clk;

  task automatic idle();
    intf.write_enable = 1'b0;
    intf.write_mask   = 3'b000;
    intf.write_data   = 3'b000;
    intf.set_carry    = 1'b0;
    intf.clear_carry  = 1'b0;
    intf.push         = 1'b0;
    intf.pop          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] mask, input logic [2:0] data);
    intf.write_enable = 1'b1;
    intf.write_mask   = mask;
    intf.write_data   = data;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    check("rst_flags", 8'(intf.read_data), 8'h0);
    check("rst_depth", 8'(intf.stk_depth), 8'h0);
    check("rst_empty", 8'(intf.stk_empty), 8'h1);
    check("rst_full",  8'(intf.stk_full),  8'h0);
    check("rst_err",   8'(intf.stk_err),   8'h0);

    // T1
    wr(3'b111, 3'b101); tick();
    check("t1_full_write", 8'(intf.read_data), 8'h5);
    wr(3'b010, 3'b010); tick();
    check("t1_masked", 8'(intf.read_data), 8'h7);

    // T2
    wr(3'b111, 3'b000); tick();
    check("t2_clear", 8'(intf.read_data), 8'h0);
    wr(3'b100, 3'b000); intf.set_carry = 1'b1; intf.clear_carry = 1'b1; tick();
    check("t2_set_wins", 8'(intf.read_data), 8'h4);

    // T3
    wr(3'b111, 3'b011); tick();
    wr(3'b111, 3'b100); intf.push = 1'b1; tick();
    check("t3_push_flags", 8'(intf.read_data), 8'h4);
    check("t3_push_depth", 8'(intf.stk_depth), 8'h1);
    check("t3_not_empty",  8'(intf.stk_empty), 8'h0);
    intf.pop = 1'b1; tick();
    check("t3_pop_flags", 8'(intf.read_data), 8'h3);
    check("t3_pop_empty", 8'(intf.stk_empty), 8'h1);

    // T4
    for (int v = 1; v <= 4; v++) begin
      wr(3'b111, 3'(v)); tick();
      intf.push = 1'b1; tick();
    end
    check("t4_full",  8'(intf.stk_full),  8'h1);
    check("t4_depth", 8'(intf.stk_depth), 8'h4);
    check("t4_no_err", 8'(intf.stk_err), 8'h0);
    intf.push = 1'b1; tick();
    check("t4_ovf_err",   8'(intf.stk_err),   8'h1);
    check("t4_ovf_depth", 8'(intf.stk_depth), 8'h4);
    for (int v = 4; v >= 1; v--) begin
      intf.pop = 1'b1; tick();
      check("t4_pop_seq", 8'(intf.read_data), 8'(v));
    end
    check("t4_drained", 8'(intf.stk_empty), 8'h1);

    // T5
    reset = 1'b1; tick();
    check("t5_err_cleared", 8'(intf.stk_err), 8'h0);
    intf.pop = 1'b1; intf.set_carry = 1'b1; tick();
    check("t5_unf_flags", 8'(intf.read_data), 8'h4);
    check("t5_unf_err",   8'(intf.stk_err),   8'h1);
    check("t5_unf_depth", 8'(intf.stk_depth), 8'h0);
    intf.push = 1'b1; tick();
    check("t5_push_depth", 8'(intf.stk_depth), 8'h1);
    intf.push = 1'b1; intf.pop = 1'b1; wr(3'b001, 3'b001); tick();
    check("t5_collide_depth", 8'(intf.stk_depth), 8'h1);
    check("t5_collide_flags", 8'(intf.read_data), 8'h5);

    // T6
    reset = 1'b1; tick();
    wr(3'b111, 3'b110); tick();
    intf.push = 1'b1; tick();
    intf.push = 1'b1; tick();
    check("t6_pre_depth", 8'(intf.stk_depth), 8'h2);
    reset = 1'b1; intf.push = 1'b1; tick();
    check("t6_depth", 8'(intf.stk_depth), 8'h0);
    check("t6_flags", 8'(intf.read_data), 8'h0);
    check("t6_err",   8'(intf.stk_err),   8'h0);
    check("t6_empty", 8'(intf.stk_empty), 8'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
